// File: rtl/ss_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ss_sequencer_pkg
// Shared definitions for the save-state sequencer and its helpers:
//   - SS_ADDR_W          width of mapper state and buffer addresses
//   - SS_SETTLE_DEF      default clk cycles ss_addr is held before capture
//   - SS_TIMEOUT_DEF     default clk cycles allowed between M2 strobes
//   - SS_LAST_ADDR_DEF   default last state address visited
//   - ss_state_t         sequencer state encoding
//   - ss_next_addr()     address increment helper
// ---------------------------------------------------------------------------
package ss_sequencer_pkg;

    localparam int SS_ADDR_W        = 8;
    localparam int SS_SETTLE_DEF    = 2;
    localparam int SS_TIMEOUT_DEF   = 4096;
    localparam int SS_LAST_ADDR_DEF = 255;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SV_SET   = 3'd1,
        SV_CAPT  = 3'd2,
        LD_FETCH = 3'd3,
        LD_LATCH = 3'd4,
        LD_WAIT1 = 3'd5,
        LD_WAIT2 = 3'd6,
        FIN      = 3'd7
    } ss_state_t;

    function automatic logic [SS_ADDR_W-1:0] ss_next_addr(input logic [SS_ADDR_W-1:0] a);
        return a + {{(SS_ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ss_sequencer_if.sv
// ---------------------------------------------------------------------------
// ss_sequencer_if
// Bundles the three sides of the save-state sequencer:
//   host control : req, req_load, abort -> busy, done, err
//   mapper port  : ss_act, ss_we, ss_addr, ss_wdat -> mapper; ss_rdat <- mapper
//   state buffer : buf_addr, buf_we, buf_wdat -> buffer; buf_rdat <- buffer
//                  (buffer read data is registered, 1-clk latency)
// Modports:
//   master - the sequencer itself
//   slave  - the surrounding host / mapper / buffer
// ---------------------------------------------------------------------------
interface ss_sequencer_if;
    import ss_sequencer_pkg::*;

    logic                 req;
    logic                 req_load;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic                 err;

    logic                 ss_act;
    logic                 ss_we;
    logic [SS_ADDR_W-1:0] ss_addr;
    logic [7:0]           ss_wdat;
    logic [7:0]           ss_rdat;

    logic [SS_ADDR_W-1:0] buf_addr;
    logic                 buf_we;
    logic [7:0]           buf_wdat;
    logic [7:0]           buf_rdat;

    modport master (
        input  req, req_load, abort, ss_rdat, buf_rdat,
        output busy, done, err, ss_act, ss_we, ss_addr, ss_wdat,
               buf_addr, buf_we, buf_wdat
    );

    modport slave (
        output req, req_load, abort, ss_rdat, buf_rdat,
        input  busy, done, err, ss_act, ss_we, ss_addr, ss_wdat,
               buf_addr, buf_we, buf_wdat
    );

endinterface

// File: rtl/ss_m2_wait.sv
// ---------------------------------------------------------------------------
// ss_m2_wait
// Tracks M2 falling-edge strobes for M2-aligned sequencers.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       clears the strobe count and the wait counter
//   en          waiting window is open; counting happens only while high
//   m2_fall     one-clk strobe per M2 falling edge (already in clk domain)
//   second      strobe seen while one strobe has already been counted
//   timeout     TIMEOUT clk cycles passed since start or the last strobe
// Flags are combinational from internal state and m2_fall; the user
// registers whatever it derives from them.
// ---------------------------------------------------------------------------
module ss_m2_wait #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic en,
    input  logic m2_fall,
    output logic second,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             seen_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            seen_first <= 1'b0;
        end else if (start) begin
            wait_cnt   <= '0;
            seen_first <= 1'b0;
        end else if (en) begin
            if (m2_fall) begin
                wait_cnt   <= '0;
                seen_first <= 1'b1;
            end else begin
                wait_cnt   <= wait_cnt + 1'b1;
            end
        end
    end

    assign second  = en && m2_fall && seen_first;
    // wait_cnt holds the number of strobe-free cycles already elapsed, so
    // this fires on the TIMEOUT-th such cycle.
    assign timeout = en && !m2_fall && (wait_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ss_sequencer.sv
// ---------------------------------------------------------------------------
// ss_sequencer
// Save-state sequencer in front of a mapper's save-state port. Walks state
// addresses 0..LAST_ADDR. Save copies each mapper byte (ss_rdat) into the
// state buffer; load replays buffer bytes into the mapper with ss_we held
// across two M2 falling edges, the second of which performs the write.
// Parameters:
//   SETTLE     clk cycles ss_addr is held before ss_rdat is captured (1..15)
//   TIMEOUT    max clk cycles waiting for one m2_fall strobe
//   LAST_ADDR  final state address visited
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   m2_fall     one-clk M2 falling-edge strobe, synchronized to clk
//   bus         host control, mapper port and buffer port (master side)
// All outputs are registered.
// ---------------------------------------------------------------------------
module ss_sequencer
    import ss_sequencer_pkg::*;
#(
    parameter int SETTLE    = SS_SETTLE_DEF,
    parameter int TIMEOUT   = SS_TIMEOUT_DEF,
    parameter int LAST_ADDR = SS_LAST_ADDR_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m2_fall,
    ss_sequencer_if.master        bus
);

    ss_state_t            state;
    logic [SS_ADDR_W-1:0] addr_q;
    logic [3:0]           settle_cnt;

    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 ss_act_q;
    logic                 ss_we_q;
    logic [SS_ADDR_W-1:0] ss_addr_q;
    logic [7:0]           ss_wdat_q;
    logic [SS_ADDR_W-1:0] buf_addr_q;
    logic                 buf_we_q;
    logic [7:0]           buf_wdat_q;

    logic                 m2_start;
    logic                 m2_en;
    logic                 m2_second;
    logic                 m2_timeout;
    logic                 at_last;

    assign at_last  = (addr_q == SS_ADDR_W'(LAST_ADDR));
    assign m2_start = (state == LD_LATCH);
    assign m2_en    = (state == LD_WAIT1) || (state == LD_WAIT2);

    ss_m2_wait #(
        .TIMEOUT (TIMEOUT)
    ) u_m2_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (m2_start),
        .en      (m2_en),
        .m2_fall (m2_fall),
        .second  (m2_second),
        .timeout (m2_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            settle_cnt <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ss_act_q   <= 1'b0;
            ss_we_q    <= 1'b0;
            ss_addr_q  <= '0;
            ss_wdat_q  <= '0;
            buf_addr_q <= '0;
            buf_we_q   <= 1'b0;
            buf_wdat_q <= '0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            done_q   <= 1'b0;
            buf_we_q <= 1'b0;

            if (state != IDLE && bus.abort) begin
                state    <= IDLE;
                busy_q   <= 1'b0;
                ss_act_q <= 1'b0;
                ss_we_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.req && !bus.abort) begin
                            err_q      <= 1'b0;
                            addr_q     <= '0;
                            settle_cnt <= '0;
                            busy_q     <= 1'b1;
                            ss_act_q   <= 1'b1;
                            ss_addr_q  <= '0;
                            buf_addr_q <= '0;
                            state      <= bus.req_load ? LD_FETCH : SV_SET;
                        end
                    end

                    SV_SET: begin
                        // ss_addr has been stable for SETTLE cycles at this edge.
                        if (settle_cnt == 4'(SETTLE - 1)) begin
                            buf_addr_q <= addr_q;
                            buf_wdat_q <= bus.ss_rdat;
                            buf_we_q   <= 1'b1;
                            state      <= SV_CAPT;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end

                    SV_CAPT: begin
                        settle_cnt <= '0;
                        if (at_last) begin
                            state <= FIN;
                        end else begin
                            addr_q    <= ss_next_addr(addr_q);
                            ss_addr_q <= ss_next_addr(addr_q);
                            state     <= SV_SET;
                        end
                    end

                    LD_FETCH: begin
                        // buf_addr is on the buffer this cycle; data arrives next.
                        state <= LD_LATCH;
                    end

                    LD_LATCH: begin
                        ss_wdat_q <= bus.buf_rdat;
                        ss_addr_q <= addr_q;
                        ss_we_q   <= 1'b1;
                        state     <= LD_WAIT1;
                    end

                    LD_WAIT1: begin
                        // The first edge may have fallen before ss_we was up.
                        if (m2_timeout) begin
                            err_q    <= 1'b1;
                            busy_q   <= 1'b0;
                            ss_act_q <= 1'b0;
                            ss_we_q  <= 1'b0;
                            state    <= IDLE;
                        end else if (m2_fall) begin
                            state <= LD_WAIT2;
                        end
                    end

                    LD_WAIT2: begin
                        if (m2_timeout) begin
                            err_q    <= 1'b1;
                            busy_q   <= 1'b0;
                            ss_act_q <= 1'b0;
                            ss_we_q  <= 1'b0;
                            state    <= IDLE;
                        end else if (m2_second) begin
                            ss_we_q <= 1'b0;
                            if (at_last) begin
                                state <= FIN;
                            end else begin
                                addr_q     <= ss_next_addr(addr_q);
                                buf_addr_q <= ss_next_addr(addr_q);
                                state      <= LD_FETCH;
                            end
                        end
                    end

                    FIN: begin
                        // ss_act is kept through FIN so the bus mux still holds
                        // the last restore byte one clk after its write edge.
                        busy_q   <= 1'b0;
                        ss_act_q <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.ss_act   = ss_act_q;
    assign bus.ss_we    = ss_we_q;
    assign bus.ss_addr  = ss_addr_q;
    assign bus.ss_wdat  = ss_wdat_q;
    assign bus.buf_addr = buf_addr_q;
    assign bus.buf_we   = buf_we_q;
    assign bus.buf_wdat = buf_wdat_q;

endmodule

// File: tb/tb_ss_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ss_sequencer
// Bench for ss_sequencer. Surrounds the DUT with a registered state buffer,
// a mapper whose readback is only valid once its address has settled, and
// an M2 source whose falling edges reach the DUT as strobes two clk later.
// The mapper records a write at each M2 falling edge during which ss_act
// and ss_we are high.
// ---------------------------------------------------------------------------
module tb_ss_sequencer;

    localparam int SETTLE    = 2;
    localparam int TIMEOUT   = 64;
    localparam int LAST_ADDR = 255;
    localparam int NBYTES    = LAST_ADDR + 1;
    localparam int SAVE_LAT  = (SETTLE + 1) * NBYTES + 2;

    logic clk = 1'b0;
    logic rst_n;
    logic m2_fall;

    ss_sequencer_if bus_if ();

    ss_sequencer #(
        .SETTLE    (SETTLE),
        .TIMEOUT   (TIMEOUT),
        .LAST_ADDR (LAST_ADDR)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m2_fall (m2_fall),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;

    logic [7:0]  mem     [NBYTES];
    logic [7:0]  exp_mem [NBYTES];
    logic [7:0]  rd_pend;
    logic [7:0]  last_ss_addr;
    int          stab;
    bit          m2_en;
    bit          m2_rand;
    int          gap_cnt;
    bit          sr0, sr1;
    logic [15:0] writes [$];
    int          done_cnt;
    bit          we_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: outputs are sampled on the falling edge, then the models
    // update and the inputs for the next rising edge are driven.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        bus_if.req   = 1'b0;
        bus_if.abort = 1'b0;
        if (bus_if.done) done_cnt++;
        if (bus_if.ss_we) we_seen = 1'b1;

        // registered buffer: data for the address seen now appears next clk
        bus_if.buf_rdat = rd_pend;
        rd_pend = mem[bus_if.buf_addr];
        if (bus_if.buf_we) mem[bus_if.buf_addr] = bus_if.buf_wdat;

        // mapper readback is garbage until the address has been held SETTLE clks
        if (bus_if.ss_addr == last_ss_addr) stab++;
        else stab = 1;
        last_ss_addr = bus_if.ss_addr;
        bus_if.ss_rdat = (stab >= SETTLE) ? (bus_if.ss_addr ^ 8'h5A) : 8'hEE;

        // M2 source: physical falling edge now, strobe two clks later
        m2_fall = sr1;
        sr1 = sr0;
        sr0 = 1'b0;
        if (m2_en) begin
            if (gap_cnt == 0) begin
                sr0 = 1'b1;
                if (bus_if.ss_we && bus_if.ss_act)
                    writes.push_back({bus_if.ss_addr, bus_if.ss_wdat});
                gap_cnt = m2_rand ? int'($urandom_range(2, 10)) : 6;
            end else begin
                gap_cnt--;
            end
        end
    endtask

    task automatic start_op(input bit load);
        bus_if.req_load = load;
        bus_if.req      = 1'b1;
        done_cnt        = 0;
        we_seen         = 1'b0;
        step();
    endtask

    task automatic wait_done(input int budget, inout int lat);
        while (done_cnt == 0 && lat < budget) begin
            step();
            lat++;
        end
    endtask

    task automatic check_save_buf(input string tag);
        int bad = 0;
        for (int k = 0; k < NBYTES; k++)
            if (mem[k] !== (8'(k) ^ 8'h5A)) bad++;
        chk(tag, bad, 0);
    endtask

    // Repeated identical writes of one byte collapse into one; what remains
    // must be bytes 0..n_exp-1 in order with the buffer contents.
    task automatic check_writes(input string tag, input int n_exp);
        int          distinct = 0;
        int          bad      = 0;
        logic [16:0] prev     = 17'h10000;
        foreach (writes[i]) begin
            if ({1'b0, writes[i]} != prev) begin
                prev = {1'b0, writes[i]};
                if (distinct >= NBYTES) bad++;
                else if (writes[i] !== {8'(distinct), exp_mem[distinct]}) bad++;
                distinct++;
            end
        end
        chk({tag, "_count"}, distinct, n_exp);
        chk({tag, "_order"}, bad, 0);
    endtask

    task automatic prep_load(input bit rnd);
        for (int k = 0; k < NBYTES; k++)
            mem[k] = rnd ? 8'($urandom) : ~8'(k);
        for (int k = 0; k < NBYTES; k++)
            exp_mem[k] = mem[k];
        writes.delete();
        m2_rand = rnd;
        gap_cnt = 0;
        m2_en   = 1'b1;
    endtask

    initial begin
        int lat;
        int t;

        rst_n           = 1'b0;
        m2_fall         = 1'b0;
        bus_if.req      = 1'b0;
        bus_if.req_load = 1'b0;
        bus_if.abort    = 1'b0;
        bus_if.ss_rdat  = 8'h00;
        bus_if.buf_rdat = 8'h00;
        rd_pend         = 8'h00;
        last_ss_addr    = 8'h00;
        stab            = 0;
        m2_en           = 1'b0;
        m2_rand         = 1'b0;
        gap_cnt         = 0;
        sr0             = 1'b0;
        sr1             = 1'b0;
        done_cnt        = 0;
        we_seen         = 1'b0;
        for (int k = 0; k < NBYTES; k++) mem[k] = 8'h00;

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {26'd0, bus_if.busy, bus_if.done, bus_if.err,
                           bus_if.ss_act, bus_if.ss_we, bus_if.buf_we}, 32'd0);
        chk("reset_data", {bus_if.ss_addr, bus_if.ss_wdat, bus_if.buf_addr, bus_if.buf_wdat}, 32'd0);
        rst_n = 1'b1;
        step();

        // save: buffer[k] = k ^ 5A, fixed latency, no mapper writes
        for (int k = 0; k < NBYTES; k++) mem[k] = 8'($urandom);
        start_op(1'b0);
        chk("save_busy_rise", bus_if.busy, 1'b1);
        lat = 1;
        wait_done(2000, lat);
        chk("save_latency", lat, SAVE_LAT);
        chk("save_end_idle", {bus_if.busy, bus_if.ss_act}, 2'b00);
        step();
        chk("save_done_pulse", bus_if.done, 1'b0);
        check_save_buf("save_buf_bad");
        chk("save_no_we", we_seen, 1'b0);

        // load: buffer[k] = ~k, M2 every 7 clk
        prep_load(1'b0);
        start_op(1'b1);
        lat = 1;
        wait_done(20000, lat);
        chk("load7_done", done_cnt, 1);
        check_writes("load7", NBYTES);
        chk("load7_end_idle", {bus_if.busy, bus_if.ss_act, bus_if.ss_we}, 3'b000);
        m2_en = 1'b0;

        // load: random buffer, random M2 spacing
        prep_load(1'b1);
        start_op(1'b1);
        lat = 1;
        wait_done(20000, lat);
        chk("loadrnd_done", done_cnt, 1);
        check_writes("loadrnd", NBYTES);
        m2_en = 1'b0;

        // load timeout: M2 stops once byte 10 has been written
        prep_load(1'b0);
        start_op(1'b1);
        t = 0;
        while (bus_if.buf_addr != 8'd11 && t < 5000) begin
            step();
            t++;
        end
        m2_en   = 1'b0;
        sr0     = 1'b0;
        sr1     = 1'b0;
        m2_fall = 1'b0;
        t = 0;
        while (!bus_if.ss_we && t < 100) begin
            step();
            t++;
        end
        chk("tmo_we_addr", {bus_if.ss_we, bus_if.ss_addr}, {1'b1, 8'd11});
        t = 0;
        while (!bus_if.err && t < 200) begin
            step();
            t++;
        end
        chk("tmo_latency", t, TIMEOUT);
        chk("tmo_ctrl", {bus_if.busy, bus_if.ss_act, bus_if.ss_we}, 3'b000);
        repeat (3) step();
        chk("tmo_no_done", done_cnt, 0);
        chk("tmo_err_hold", bus_if.err, 1'b1);
        check_writes("tmo", 11);

        // save again: err clears on accept; a req while busy is ignored
        start_op(1'b0);
        chk("err_clear", {bus_if.err, bus_if.busy}, 2'b01);
        lat = 1;
        repeat (99) begin
            step();
            lat++;
        end
        bus_if.req_load = 1'b1;
        bus_if.req      = 1'b1;
        wait_done(2000, lat);
        chk("busy_req_latency", lat, SAVE_LAT);
        check_save_buf("busy_req_buf_bad");
        chk("busy_req_no_we", we_seen, 1'b0);

        // abort while capturing byte 100
        for (int k = 0; k < NBYTES; k++) mem[k] = 8'h00;
        start_op(1'b0);
        t = 0;
        while (!(bus_if.buf_we && bus_if.buf_addr == 8'd100) && t < 1000) begin
            step();
            t++;
        end
        chk("abort_at_capt", {bus_if.buf_we, bus_if.buf_addr}, {1'b1, 8'd100});
        bus_if.abort = 1'b1;
        step();
        chk("abort_ctrl", {bus_if.busy, bus_if.buf_we, bus_if.ss_act, bus_if.ss_we, bus_if.done}, 5'b00000);
        repeat (10) step();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_stays_idle", {bus_if.busy, bus_if.err}, 2'b00);

        // req together with abort in IDLE
        bus_if.req_load = 1'b0;
        bus_if.req      = 1'b1;
        bus_if.abort    = 1'b1;
        done_cnt        = 0;
        step();
        chk("req_abort_idle", {bus_if.busy, bus_if.ss_act}, 2'b00);
        repeat (5) step();
        chk("req_abort_no_op", {bus_if.busy, bus_if.buf_we, 8'(done_cnt)}, 10'd0);

        // asynchronous reset in the middle of a load, then a clean restart
        prep_load(1'b0);
        start_op(1'b1);
        t = 0;
        while (!(bus_if.ss_we && bus_if.ss_addr == 8'd50) && t < 5000) begin
            step();
            t++;
        end
        chk("rst_reach", {bus_if.ss_we, bus_if.ss_addr}, {1'b1, 8'd50});
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_ctrl", {26'd0, bus_if.busy, bus_if.done, bus_if.err,
                               bus_if.ss_act, bus_if.ss_we, bus_if.buf_we}, 32'd0);
        chk("rst_async_data", {bus_if.ss_addr, bus_if.ss_wdat, bus_if.buf_addr, bus_if.buf_wdat}, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        m2_en   = 1'b0;
        sr0     = 1'b0;
        sr1     = 1'b0;
        m2_fall = 1'b0;
        rd_pend = 8'h00;
        step();
        prep_load(1'b0);
        start_op(1'b1);
        lat = 1;
        wait_done(20000, lat);
        chk("restart_done", done_cnt, 1);
        check_writes("restart", NBYTES);
        m2_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
